// File: rtl/pwl_table_loader.sv
// pwl_table_loader
// Writes a streamed PWL segment table into the inactive bank of a
// double-buffered table RAM, then flips the bank select once a complete,
// correctly framed table has landed. The evaluator only ever reads the bank
// selected by bank_sel, so a table swap is atomic from its point of view.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for cfg_start; beats are not accepted
// LOAD   | accepting beats, writing them to {~bank_sel, cnt}
// COMMIT | final write on the RAM port; bank_sel flips at the next edge

module pwl_table_loader #(
    parameter int addr_width   = 8,
    parameter int offset_width = 18,
    parameter int slope_width  = 18
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_start,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [offset_width+slope_width-1:0]  cfg_data,
    input  logic                                 cfg_last,
    output logic                                 wr_en,
    output logic [addr_width:0]                  wr_addr,
    output logic [offset_width+slope_width-1:0]  wr_data,
    output logic                                 bank_sel,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [addr_width-1:0] cnt;
    logic [addr_width-1:0] cnt_next;
    logic                  beat;
    logic                  cnt_at_end;
    logic                  err_set;
    logic                  err_clr;

    // State register and entry counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic, handshake and framing checks.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cfg_ready  = 1'b0;
        busy       = 1'b0;
        beat       = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        cnt_at_end = (cnt == {addr_width{1'b1}});
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    err_clr    = 1'b1;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                beat      = cfg_valid;
                if (beat) begin
                    cnt_next = cnt + 1'b1;
                    if (cfg_last && cnt_at_end) begin
                        state_next = COMMIT;
                    end else if (cfg_last || cnt_at_end) begin
                        // short table (early last) or long table (no last on final slot)
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered RAM write port; the offending beat of an error is still written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= beat;
            if (beat) begin
                wr_addr <= {~bank_sel, cnt};
                wr_data <= cfg_data;
            end
        end
    end

    // Bank flip, completion pulse and sticky framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == COMMIT) begin
                bank_sel <= ~bank_sel;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwl_table_loader.sv
// Directed bench for pwl_table_loader with a 4-entry table (addr_width=2).
module tb_pwl_table_loader;

    localparam int AW = 2;
    localparam int DW = 36;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data;
    logic          cfg_last;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          bank_sel;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    // write log and done count, collected on the falling edge
    logic [AW:0]   log_addr[$];
    logic [DW-1:0] log_data[$];
    int            done_cnt = 0;

    pwl_table_loader #(
        .addr_width  (AW),
        .offset_width(18),
        .slope_width (18)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .cfg_last (cfg_last),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bank_sel (bank_sel),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (!rst && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse cfg_start, then stream beats i=0..n-1 with data 0x11*(i+1) and
    // cfg_last on beat last_idx, until the loader stops accepting.
    task automatic do_load(input int n, input int last_idx, input bit gaps, input bit mid_start);
        int  i;
        int  guard;
        bit  acc;
        i     = 0;
        guard = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("start_ready", cfg_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_err_clr", err, 0);
        while (i < n && guard < 200) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = DW'(17 * (i + 1));
                cfg_last  = (i == last_idx);
            end
            cfg_start = (mid_start && guard == 3);
            acc = cfg_valid && cfg_ready;
            tick();
            cfg_start = 1'b0;
            if (acc) i++;
            if (!cfg_ready) break;
        end
        if (guard >= 200) chk("load_timeout", 1, 0);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int base;
        int dbase;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        tick();
        tick();
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bank", bank_sel, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // 1: clean load, cycle by cycle
        dbase = done_cnt;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t1_ready", cfg_ready, 1);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = DW'(17 * (i + 1));
            cfg_last  = (i == 3);
            tick();
            chk("t1_wr_en", wr_en, 1);
            chk("t1_wr_addr", wr_addr, 4 + i);
            chk("t1_wr_data", wr_data, 17 * (i + 1));
            chk("t1_bank_before", bank_sel, 0);
            chk("t1_ready_beat", cfg_ready, (i < 3) ? 1 : 0);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        chk("t1_commit_busy", busy, 1);
        chk("t1_commit_done", done, 0);
        tick();
        chk("t1_bank_flip", bank_sel, 1);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_wr_en_end", wr_en, 0);
        chk("t1_err", err, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_done_cnt", done_cnt - dbase, 1);

        // 2: second clean load goes to bank 0
        base = log_addr.size();
        dbase = done_cnt;
        do_load(4, 3, 1'b0, 1'b0);
        chk("t2_nwr", log_addr.size() - base, 4);
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++) begin
            chk("t2_addr", log_addr[base+i], i);
            chk("t2_data", log_data[base+i], 17 * (i + 1));
        end
        chk("t2_bank", bank_sel, 0);
        chk("t2_done_cnt", done_cnt - dbase, 1);
        chk("t2_err", err, 0);

        // 3: short table, last on beat 2
        base = log_addr.size();
        dbase = done_cnt;
        do_load(4, 1, 1'b0, 1'b0);
        chk("t3_nwr", log_addr.size() - base, 2);
        for (int i = 0; i < 2 && base + i < log_addr.size(); i++)
            chk("t3_addr", log_addr[base+i], 4 + i);
        chk("t3_err", err, 1);
        chk("t3_bank", bank_sel, 0);
        chk("t3_busy", busy, 0);
        chk("t3_done_cnt", done_cnt - dbase, 0);

        // 4: long table, no last on beat 4; next do_load start clears err
        base = log_addr.size();
        dbase = done_cnt;
        do_load(5, 99, 1'b0, 1'b0);
        chk("t4_err", err, 1);
        chk("t4_busy", busy, 0);
        cfg_valid = 1'b1;
        cfg_data  = DW'(85);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t4_no_ready", cfg_ready, 0);
            chk("t4_no_wr", wr_en, 0);
        end
        cfg_valid = 1'b0;
        chk("t4_nwr", log_addr.size() - base, 4);
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++)
            chk("t4_addr", log_addr[base+i], 4 + i);
        chk("t4_bank", bank_sel, 0);
        chk("t4_done_cnt", done_cnt - dbase, 0);

        // 5: bursty valid with a stray cfg_start mid-load
        base = log_addr.size();
        dbase = done_cnt;
        do_load(4, 3, 1'b1, 1'b1);
        chk("t5_nwr", log_addr.size() - base, 4);
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++) begin
            chk("t5_addr", log_addr[base+i], 4 + i);
            chk("t5_data", log_data[base+i], 17 * (i + 1));
        end
        chk("t5_bank", bank_sel, 1);
        chk("t5_done_cnt", done_cnt - dbase, 1);
        chk("t5_err", err, 0);

        // 6: reset after two beats, then a full load
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = DW'(17);
        cfg_last  = 1'b0;
        tick();
        cfg_data  = DW'(34);
        tick();
        chk("t6_pre_wr", wr_en, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_bank", bank_sel, 0);
        chk("t6_rst_ready", cfg_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_err", err, 0);
        cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        base = log_addr.size();
        dbase = done_cnt;
        do_load(4, 3, 1'b0, 1'b0);
        chk("t6_nwr", log_addr.size() - base, 4);
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++) begin
            chk("t6_addr", log_addr[base+i], 4 + i);
            chk("t6_data", log_data[base+i], 17 * (i + 1));
        end
        chk("t6_bank", bank_sel, 1);
        chk("t6_done_cnt", done_cnt - dbase, 1);
        chk("t6_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
